// File: rtl/dc_sweep_sequencer.sv
// Stepped DC sweep sequencer: for each DAC code it loads the source, waits a
// settling interval, averages 2^AVG_LOG2 load-ADC samples and emits one record.
module dc_sweep_sequencer #(
  parameter int DAC_W         = 12,
  parameter int ADC_W         = 12,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DAC_W-1:0]          start_code,
  input  logic [DAC_W-1:0]          stop_code,
  input  logic [DAC_W-1:0]          step_code,
  output logic                      busy,
  output logic [DAC_W-1:0]          dac_code,
  output logic                      dac_load,
  output logic                      adc_req,
  input  logic                      adc_ack,
  input  logic [ADC_W-1:0]          adc_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DAC_W-1:0]          res_code,
  output logic [ADC_W+AVG_LOG2-1:0] res_sum,
  output logic                      done
);

  localparam int SUM_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int STL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] N_SAMP   = CNT_W'(1 << AVG_LOG2);
  localparam logic [STL_W-1:0] STL_INIT = STL_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_SAMPLE, S_EMIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DAC_W-1:0]   dac_code_q, dac_code_d;
  logic [DAC_W-1:0]   stop_q, stop_d;
  logic [DAC_W-1:0]   step_q, step_d;
  logic [DAC_W-1:0]   res_code_q, res_code_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STL_W-1:0]   stl_q, stl_d;
  logic [DAC_W:0]     next_code;
  logic               busy_q, busy_d;
  logic               dac_load_q, dac_load_d;
  logic               adc_req_q, adc_req_d;
  logic               res_valid_q, res_valid_d;
  logic               done_q, done_d;

  always_comb begin
    state_d    = state_q;
    dac_code_d = dac_code_q;
    stop_d     = stop_q;
    step_d     = step_q;
    res_code_d = res_code_q;
    res_sum_d  = res_sum_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    stl_d      = stl_q;
    // Extra MSB catches wrap past the top code and forces completion.
    next_code  = {1'b0, dac_code_q} + {1'b0, step_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stop_d = stop_code;
          step_d = step_code;
          if (start_code > stop_code) begin
            state_d = S_DONE;
          end else begin
            dac_code_d = start_code;
            state_d    = S_SET;
          end
        end
      end
      S_SET: begin
        stl_d   = STL_INIT;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (stl_q == '0) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          stl_d = stl_q - STL_W'(1);
        end
      end
      S_SAMPLE: begin
        if (adc_ack) begin
          acc_d = acc_q + SUM_W'(adc_data);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == N_SAMP) begin
            res_code_d = dac_code_q;
            res_sum_d  = acc_d;
            state_d    = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          if (step_q == '0 || dac_code_q == stop_q || next_code > {1'b0, stop_q}) begin
            state_d = S_DONE;
          end else begin
            dac_code_d = next_code[DAC_W-1:0];
            state_d    = S_SET;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle record handshake.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      dac_code_d = dac_code_q;
      res_code_d = res_code_q;
      res_sum_d  = res_sum_q;
    end

    busy_d      = (state_d != S_IDLE);
    dac_load_d  = (state_d == S_SET);
    adc_req_d   = (state_d == S_SAMPLE);
    res_valid_d = (state_d == S_EMIT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dac_code_q  <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      res_code_q  <= '0;
      res_sum_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      stl_q       <= '0;
      busy_q      <= 1'b0;
      dac_load_q  <= 1'b0;
      adc_req_q   <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_code_q  <= dac_code_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      res_code_q  <= res_code_d;
      res_sum_q   <= res_sum_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      stl_q       <= stl_d;
      busy_q      <= busy_d;
      dac_load_q  <= dac_load_d;
      adc_req_q   <= adc_req_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign dac_code  = dac_code_q;
  assign dac_load  = dac_load_q;
  assign adc_req   = adc_req_q;
  assign res_valid = res_valid_q;
  assign res_code  = res_code_q;
  assign res_sum   = res_sum_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Bench for dc_sweep_sequencer: table of sweeps against a sample/record
// scoreboard, plus hand-written latency, abort and mid-sweep reset sequences.
module tb_dc_sweep_sequencer;

  localparam int DAC_W = 12;
  localparam int ADC_W = 12;
  localparam int AVG_LOG2 = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int NSAMP = 1 << AVG_LOG2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start, abort;
  logic [DAC_W-1:0]          start_code, stop_code, step_code;
  logic                      busy, dac_load, adc_req, adc_ack;
  logic [DAC_W-1:0]          dac_code, res_code;
  logic [ADC_W-1:0]          adc_data;
  logic                      res_valid, res_ready, done;
  logic [ADC_W+AVG_LOG2-1:0] res_sum;

  dc_sweep_sequencer #(
    .DAC_W(DAC_W), .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_code(start_code), .stop_code(stop_code), .step_code(step_code),
    .busy(busy), .dac_code(dac_code), .dac_load(dac_load),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_code(res_code), .res_sum(res_sum), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard state shared with the monitor.
  int recs, dones, loads, last_code;
  int mdl_acc, mdl_n, mdl_code, mdl_step;

  always @(negedge clk) begin
    if (!rst) begin
      if (dac_load) begin
        loads++;
        mdl_acc = 0;
        mdl_n   = 0;
      end
      if (adc_req && adc_ack) begin
        mdl_acc += int'(adc_data);
        mdl_n++;
      end
      if (res_valid) begin
        check("res_sum", int'(res_sum), mdl_acc);
        check("res_code", int'(res_code), mdl_code);
        if (res_ready && !abort) begin
          check("samples_per_point", mdl_n, NSAMP);
          last_code = int'(res_code);
          recs++;
          mdl_code += mdl_step;
        end
      end
      if (done) dones++;
    end
  end

  typedef struct {
    logic [DAC_W-1:0] st;
    logic [DAC_W-1:0] sp;
    logic [DAC_W-1:0] stp;
    logic [ADC_W-1:0] data;
    bit               stall;
    int               exp_recs;
    int               exp_last;
  } vec_t;

  vec_t vecs[9];

  task automatic drive(input bit stall, input logic [ADC_W-1:0] data);
    if (stall) begin
      adc_data  = ADC_W'($urandom_range(0, 4095));
      adc_ack   = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
    end else begin
      adc_data  = data;
      adc_ack   = 1'b1;
      res_ready = 1'b1;
    end
  endtask

  // Leaves the caller #1 after the edge that accepted start.
  task automatic start_sweep(input int st, input int sp, input int stp);
    recs = 0; dones = 0; loads = 0; last_code = -1;
    mdl_code = st; mdl_step = stp;
    start_code = DAC_W'(st);
    stop_code  = DAC_W'(sp);
    step_code  = DAC_W'(stp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return adc_req;
      1:       return res_valid;
      2:       return dac_load;
      default: return done;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int max, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!sel_sig(sel) && n < max);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    drive(v.stall, v.data);
    start_sweep(int'(v.st), int'(v.sp), int'(v.stp));
    check("busy_after_start", int'(busy), 1);
    if (v.exp_recs > 0) check("first_dac_load", int'(dac_load), 1);
    else                check("done_right_after_start", int'(done), 1);
    cyc = 0;
    while (dones == 0 && cyc < 2000) begin
      drive(v.stall, v.data);
      @(posedge clk); #1;
      cyc++;
    end
    drive(1'b0, v.data);
    check("busy_after_done", int'(busy), 0);
    idle(3);
    check("done_pulses", dones, 1);
    check("records", recs, v.exp_recs);
    check("dac_loads", loads, v.exp_recs);
    if (v.exp_recs > 0) check("last_code", last_code, v.exp_last);
  endtask

  initial begin
    int n;
    vecs[0] = '{12'd0,    12'd8,    12'd4,    12'd100,  1'b0, 3, 8};
    vecs[1] = '{12'd5,    12'd5,    12'd1,    12'd7,    1'b0, 1, 5};
    vecs[2] = '{12'd6,    12'd5,    12'd1,    12'd0,    1'b0, 0, 0};
    vecs[3] = '{12'd3,    12'd20,   12'd0,    12'd9,    1'b0, 1, 3};
    vecs[4] = '{12'd4090, 12'd4095, 12'd4,    12'd4095, 1'b0, 2, 4094};
    vecs[5] = '{12'd4092, 12'd4095, 12'd3,    12'd1,    1'b0, 2, 4095};
    vecs[6] = '{12'd0,    12'd4095, 12'd4095, 12'd2048, 1'b0, 2, 4095};
    vecs[7] = '{12'd10,   12'd30,   12'd7,    12'd0,    1'b1, 3, 24};
    vecs[8] = '{12'd0,    12'd6,    12'd3,    12'd0,    1'b1, 3, 6};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_code = '0; stop_code = '0; step_code = '0;
    adc_ack = 1'b0; adc_data = '0; res_ready = 1'b0;
    recs = 0; dones = 0; loads = 0; last_code = -1;
    mdl_acc = 0; mdl_n = 0; mdl_code = 0; mdl_step = 0;
    idle(2);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_dac_code", int'(dac_code), 0);
    check("rst_dac_load", int'(dac_load), 0);
    check("rst_adc_req", int'(adc_req), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_code", int'(res_code), 0);
    check("rst_res_sum", int'(res_sum), 0);
    check("rst_done", int'(done), 0);

    // Per-point latency with ack and ready held high
    drive(1'b0, 12'd100);
    start_sweep(0, 8, 4);
    check("lat_dac_load", int'(dac_load), 1);
    wait_until(0, 50, n);
    check("lat_to_adc_req", n, SETTLE_CYCLES + 1);
    wait_until(1, 50, n);
    check("lat_to_res_valid", n, NSAMP);
    wait_until(2, 50, n);
    check("lat_to_next_load", n, 1);
    check("lat_next_code", int'(dac_code), 4);
    wait_until(3, 200, n);
    check("lat_done_seen", int'(done), 1);
    idle(3);
    check("lat_records", recs, 3);

    // Abort during SETTLE
    start_sweep(8, 20, 4);
    idle(2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_settle_busy", int'(busy), 0);
    check("abort_settle_dac_load", int'(dac_load), 0);
    check("abort_settle_dac_code", int'(dac_code), 8);
    idle(30);
    check("abort_settle_recs", recs, 0);
    check("abort_settle_dones", dones, 0);

    // Abort during SAMPLE
    adc_ack = 1'b0;
    start_sweep(8, 20, 4);
    wait_until(0, 50, n);
    check("abort_sample_req_seen", int'(adc_req), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    adc_ack = 1'b1;
    check("abort_sample_adc_req", int'(adc_req), 0);
    check("abort_sample_busy", int'(busy), 0);
    idle(30);
    check("abort_sample_recs", recs, 0);
    check("abort_sample_dones", dones, 0);

    // Abort in the same cycle as the record handshake
    res_ready = 1'b0;
    start_sweep(8, 20, 4);
    wait_until(1, 50, n);
    check("abort_emit_valid_seen", int'(res_valid), 1);
    res_ready = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_emit_res_valid", int'(res_valid), 0);
    check("abort_emit_busy", int'(busy), 0);
    check("abort_emit_dac_load", int'(dac_load), 0);
    check("abort_emit_dac_code", int'(dac_code), 8);
    idle(30);
    check("abort_emit_recs", recs, 0);
    check("abort_emit_dones", dones, 0);

    // Table-driven sweeps
    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of SAMPLE
    adc_ack = 1'b0;
    start_sweep(0, 8, 4);
    wait_until(0, 50, n);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_adc_req", int'(adc_req), 0);
    check("mid_rst_dac_code", int'(dac_code), 0);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_res_code", int'(res_code), 0);
    check("mid_rst_res_sum", int'(res_sum), 0);
    check("mid_rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    adc_ack = 1'b1;
    idle(20);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_recs", recs, 0);
    check("post_rst_dones", dones, 0);

    // Clean sweep after reset
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
